// File: rtl/mult_pkg.sv
// Shared widths, state codes and saturation limits for mult_8bit / div_8bit.
// Also provides two's-complement magnitude helpers.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } state_e;

  localparam logic [OP_W-1:0] Q_MAX = 8'h7F;
  localparam logic [OP_W-1:0] Q_MIN = 8'h80;

  // |-32768| = 32768 and |-128| = 128 still fit as unsigned.
  function automatic logic [PROD_W-1:0] mag16(
    input logic [PROD_W-1:0] v
  );
    return v[PROD_W-1] ? PROD_W'(-v) : v;
  endfunction

  function automatic logic [OP_W-1:0] mag8(
    input logic [OP_W-1:0] v
  );
    return v[OP_W-1] ? OP_W'(-v) : v;
  endfunction

endpackage

// File: rtl/div_8bit_if.sv
// init/busy handshake bundle of the signed divider.
// master drives operands, slave returns results.
interface div_8bit_if;
  import mult_pkg::*;

  logic              init;
  logic [PROD_W-1:0] a;
  logic [OP_W-1:0]   b;
  logic [OP_W-1:0]   q;
  logic [OP_W-1:0]   r;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              dbz;

  modport master (
    output init, a, b,
    input  q, r, busy, done, ovf, dbz
  );

  modport slave (
    input  init, a, b,
    output q, r, busy, done, ovf, dbz
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes.
// Shifts bit_in into rem and subtracts mag_b when it fits.
module div_step
  import mult_pkg::*;
(
  input  logic [OP_W:0]   rem,
  input  logic            bit_in,
  input  logic [OP_W-1:0] mag_b,
  output logic [OP_W:0]   next_rem,
  output logic            q_bit
);

  logic [OP_W+1:0] trial;
  logic [OP_W+1:0] diff;

  always_comb begin
    trial    = {rem, bit_in};
    diff     = trial - {2'b00, mag_b};
    q_bit    = (trial >= {2'b00, mag_b});
    next_rem = q_bit ? diff[OP_W:0] : trial[OP_W:0];
  end

endmodule

// File: rtl/div_8bit.sv
// Sequential signed 16/8 divider, restoring radix-2 on magnitudes.
// Define SATURATE_EN to clamp q on overflow and divide-by-zero.
module div_8bit
  import mult_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  div_8bit_if.slave bus
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              zero_q, zero_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [PROD_W-1:0] quo_q, quo_d;
  logic [OP_W-1:0]   magb_q, magb_d;
  logic [OP_W:0]     rem_q, rem_d;
  logic [OP_W-1:0]   alo_q, alo_d;
  logic [OP_W-1:0]   q_q, q_d;
  logic [OP_W-1:0]   r_q, r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              dbz_q, dbz_d;

  logic [OP_W:0]     step_rem;
  logic              step_bit;
  logic [PROD_W-1:0] sq;
  logic [OP_W-1:0]   sr;
  logic [8:0]        sq_top;
  logic              fix_ovf;

  // quo_q doubles as dividend shifter and quotient collector
  div_step u_step (
    .rem      (rem_q),
    .bit_in   (quo_q[PROD_W-1]),
    .mag_b    (magb_q),
    .next_rem (step_rem),
    .q_bit    (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    magb_d  = magb_q;
    rem_d   = rem_q;
    alo_d   = alo_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    sq      = qneg_q ? PROD_W'(-quo_q) : quo_q;
    sr      = rneg_q ? OP_W'(-rem_q[OP_W-1:0])
                     : rem_q[OP_W-1:0];
    sq_top  = sq[PROD_W-1:OP_W-1];
    fix_ovf = zero_q | ~((&sq_top) | ~(|sq_top));

    unique case (state_q)
      IDLE: begin
        if (bus.init) begin
          qneg_d  = bus.a[PROD_W-1] ^ bus.b[OP_W-1];
          rneg_d  = bus.a[PROD_W-1];
          quo_d   = mag16(bus.a);
          magb_d  = mag8(bus.b);
          alo_d   = bus.a[OP_W-1:0];
          rem_d   = '0;
          cnt_d   = '0;
          zero_d  = (bus.b == '0);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // zero divisor passes through once, giving a 2-edge latency
        if (zero_q) begin
          state_d = FIX;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[PROD_W-2:0], step_bit};
          cnt_d = 4'(cnt_q + 4'd1);
          if (cnt_q == 4'd15) state_d = FIX;
        end
      end
      FIX: begin
        ovf_d   = fix_ovf;
        dbz_d   = zero_q;
`ifdef SATURATE_EN
        if (zero_q) begin
          q_d = rneg_q ? Q_MIN : Q_MAX;
          r_d = alo_q;
        end else if (fix_ovf) begin
          q_d = qneg_q ? Q_MIN : Q_MAX;
          r_d = sr;
        end else begin
          q_d = sq[OP_W-1:0];
          r_d = sr;
        end
`else
        if (zero_q) begin
          q_d = 8'hFF;
          r_d = alo_q;
        end else begin
          q_d = sq[OP_W-1:0];
          r_d = sr;
        end
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      magb_q  <= '0;
      rem_q   <= '0;
      alo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      magb_q  <= magb_d;
      rem_q   <= rem_d;
      alo_q   <= alo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_div_8bit.sv
// Scoreboard bench for div_8bit: directed vectors plus identity sweep.
// Build with +define+SATURATE_EN to check the saturating variant.
module tb_div_8bit;
  import mult_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  div_8bit_if bus ();

  div_8bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dbz;
    int          lat;
    int          start;
    bit          ident;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t e);
    int lat;
    int ai, bi, qi, ri, tq;
    bit xo, ok;
    lat = cyc - e.start;
    if (e.ident) begin
      ai = int'($signed(e.a));
      bi = int'($signed(e.b));
      qi = int'($signed(bus.q));
      ri = int'($signed(bus.r));
      tq = ai / bi;
      xo = (tq > 127) || (tq < -128);
      total++;
      if (bus.ovf !== xo || bus.dbz !== 1'b0) begin
        bad++;
        $display("FAIL %s flags a=%0d b=%0d got ovf=%b dbz=%b want ovf=%b dbz=0",
                 e.name, ai, bi, bus.ovf, bus.dbz, xo);
      end
      if (!xo) begin
        total++;
        ok = (qi * bi + ri == ai)
          && ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi))
          && (ri == 0 || ((ri < 0) == (ai < 0)));
        if (!ok) begin
          bad++;
          $display("FAIL %s identity a=%0d b=%0d got q=%0d r=%0d want q=%0d r=%0d",
                   e.name, ai, bi, qi, ri, tq, ai - tq * bi);
        end
      end
    end else begin
      total++;
      if ({bus.q, bus.r, bus.ovf, bus.dbz} !== {e.q, e.r, e.ovf, e.dbz}) begin
        bad++;
        $display("FAIL %s result got q=%h r=%h ovf=%b dbz=%b want q=%h r=%h ovf=%b dbz=%b",
                 e.name, bus.q, bus.r, bus.ovf, bus.dbz, e.q, e.r, e.ovf, e.dbz);
      end
      total++;
      if (lat != e.lat) begin
        bad++;
        $display("FAIL %s latency got %0d want %0d", e.name, lat, e.lat);
      end
      total++;
      if (busy_run != e.lat) begin
        bad++;
        $display("FAIL %s busy_cycles got %0d want %0d", e.name, busy_run, e.lat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got q=%h r=%h want no done", bus.q, bus.r);
      end else begin
        check(sb.pop_front());
      end
      busy_run = 0;
    end else if (bus.busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  function automatic exp_t mk(input string nm, input int av, input int bv,
                              input int qu, input int qs, input int rv,
                              input bit ov, input bit dz, input int lat);
    exp_t e;
    e.name  = nm;
    e.a     = 16'(av);
    e.b     = 8'(bv);
`ifdef SATURATE_EN
    e.q     = 8'(qs);
`else
    e.q     = 8'(qu);
`endif
    e.r     = 8'(rv);
    e.ovf   = ov;
    e.dbz   = dz;
    e.lat   = lat;
    e.start = 0;
    e.ident = 1'b0;
    return e;
  endfunction

  task automatic issue(input exp_t e);
    @(negedge clk);
    bus.a    = e.a;
    bus.b    = e.b;
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    bus.init = 1'b0;
    e.start  = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input exp_t e);
    issue(e);
    drain();
  endtask

  initial begin
    exp_t e1, e2;
    bus.init = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    #12;
    total++;
    if ({bus.q, bus.r, bus.busy, bus.done, bus.ovf, bus.dbz} !== 20'h0) begin
      bad++;
      $display("FAIL reset_state got q=%h r=%h busy=%b done=%b want all 0",
               bus.q, bus.r, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;

    run(mk("p55_m5",    55,    -5,  8'hF5, 8'hF5, 0,     0, 0, 17));
    run(mk("m55_p5",    -55,   5,   8'hF5, 8'hF5, 0,     0, 0, 17));
    run(mk("p100_m7",   100,   -7,  8'hF2, 8'hF2, 2,     0, 0, 17));
    run(mk("m100_p7",   -100,  7,   8'hF2, 8'hF2, 8'hFE, 0, 0, 17));
    run(mk("p1000_p3",  1000,  3,   8'h4D, 8'h7F, 1,     1, 0, 17));
    run(mk("min_m1",    -32768, -1, 8'h00, 8'h7F, 0,     1, 0, 17));
    run(mk("p20_dbz",   20,    0,   8'hFF, 8'h7F, 8'h14, 1, 1, 2));
    run(mk("m20_dbz",   -20,   0,   8'hFF, 8'h80, 8'hEC, 1, 1, 2));

    // abort mid-calculation with non-zero outputs still held
    @(negedge clk);
    bus.a    = 16'd55;
    bus.b    = 8'(-5);
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    bus.init = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.q, bus.r, bus.busy, bus.done, bus.ovf, bus.dbz} !== 20'h0) begin
      bad++;
      $display("FAIL async_reset got q=%h r=%h busy=%b done=%b ovf=%b dbz=%b want all 0",
               bus.q, bus.r, bus.busy, bus.done, bus.ovf, bus.dbz);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    run(mk("after_rst", 55, -5, 8'hF5, 8'hF5, 0, 0, 0, 17));

    // second init while busy must be ignored
    issue(mk("busy_ign", 100, -7, 8'hF2, 8'hF2, 2, 0, 0, 17));
    repeat (3) @(negedge clk);
    bus.a    = 16'd1;
    bus.b    = 8'd1;
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    // init held high: back-to-back with one IDLE cycle between
    e1 = mk("held_1", -55, 5, 8'hF5, 8'hF5, 0, 0, 0, 17);
    e2 = mk("held_2", -55, 5, 8'hF5, 8'hF5, 0, 0, 0, 17);
    @(negedge clk);
    bus.a    = e1.a;
    bus.b    = e1.b;
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    e1.start = cyc;
    e2.start = cyc + 18;
    sb.push_back(e1);
    sb.push_back(e2);
    repeat (18) @(posedge clk);
    #1;
    bus.init = 1'b0;
    drain();

    for (int bi = -128; bi < 128; bi++) begin
      if (bi != 0) begin
        exp_t ei;
        ei       = mk("sweep", int'($urandom_range(0, 65535)), bi, 0, 0, 0, 0, 0, 17);
        ei.ident = 1'b1;
        run(ei);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
